// File: rtl/io_bridge.sv
// io_bridge: decodes the CPU byte bus to RAM or the MMIO window; owns the UART TX FIFO, RX pop, cycle counter and stop logic.
// Read data returns one cycle after the request; io_buffer_full gives early TX back-pressure. RX pop path enabled by IO_BRIDGE_RX_EN.
module io_bridge #(
  parameter int TX_DEPTH_BIT = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_wr,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ack,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_BIT;
  localparam logic [TX_DEPTH_BIT:0] DEPTH_C  = {1'b1, {TX_DEPTH_BIT{1'b0}}};
  localparam logic [TX_DEPTH_BIT:0] MARGIN_C = FULL_MARGIN[TX_DEPTH_BIT:0];

  typedef enum logic [1:0] {
    SEL_HOLE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  logic [17:0] addr;
  logic        is_io;
  logic        is_ram;
  logic        unused_hi;

  assign addr      = cpu_a[17:0];
  assign is_io     = (addr[17:16] == 2'b11);
  assign is_ram    = ~addr[17];
  assign unused_hi = ^cpu_a[31:18];

`ifndef IO_BRIDGE_RX_EN
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid};
`endif

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = cpu_wr & is_ram & ~rst_in;

  sel_e                    sel_q, sel_d;
  logic [7:0]              io_rdata_q, io_rdata_d;
  logic [31:0]             snap_q, snap_d;
  logic [31:0]             cyc_q;
  logic [7:0]              fifo_q [DEPTH];
  logic [TX_DEPTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [TX_DEPTH_BIT:0]   count_q, count_d;
  logic                    stop_q, stop_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    push_req, push_ok, pop, full;
  logic [7:0]              push_byte;

  // Read side: decode region, capture IO read data, snapshot the counter.
  always_comb begin
    sel_d      = is_io ? SEL_IO : (is_ram ? SEL_RAM : SEL_HOLE);
    io_rdata_d = 8'h00;
    snap_d     = snap_q;
    rx_ack     = 1'b0;
    if (!cpu_wr && is_io) begin
      case (addr[15:0])
`ifdef IO_BRIDGE_RX_EN
        16'h0000: begin
          if (rx_valid && !rst_in) begin
            rx_ack     = 1'b1;
            io_rdata_d = rx_data;
          end
        end
`endif
        16'h0004: begin
          snap_d     = cyc_q;
          io_rdata_d = cyc_q[7:0];
        end
        16'h0005: io_rdata_d = snap_q[15:8];
        16'h0006: io_rdata_d = snap_q[23:16];
        16'h0007: io_rdata_d = snap_q[31:24];
        default:  io_rdata_d = 8'h00;
      endcase
    end
  end

  assign cpu_din = (sel_q == SEL_RAM) ? ram_dout :
                   (sel_q == SEL_IO)  ? io_rdata_q : 8'h00;

  // Write side: 0x30000 pushes nonzero bytes, 0x30004 pushes a 0x00 terminator and arms stop.
  always_comb begin
    push_req  = 1'b0;
    push_byte = cpu_dout;
    stop_d    = stop_q;
    if (cpu_wr && is_io) begin
      if (addr[15:0] == 16'h0000 && cpu_dout != 8'h00) begin
        push_req = 1'b1;
      end else if (addr[15:0] == 16'h0004) begin
        push_req  = 1'b1;
        push_byte = 8'h00;
        stop_d    = 1'b1;
      end
    end
  end

  assign tx_valid = (count_q != '0);
  assign tx_data  = fifo_q[head_q];
  assign full     = (count_q == DEPTH_C);
  assign pop      = tx_valid & tx_ready;
  // A push at full still lands when the head drains in the same cycle.
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push_ok ? tail_q + 1'b1 : tail_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q | (push_req & full & ~pop);
    done_d = done_q | (stop_q & (count_q == '0));
  end

  assign io_buffer_full = ((DEPTH_C - count_q) <= MARGIN_C);
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q      <= SEL_HOLE;
      io_rdata_q <= 8'h00;
      snap_q     <= 32'h0;
      cyc_q      <= 32'h0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      io_rdata_q <= io_rdata_d;
      snap_q     <= snap_d;
      cyc_q      <= cyc_q + 32'd1;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) begin
      fifo_q[tail_q] <= push_byte;
    end
  end

endmodule
